// File: rtl/pipe_datapath_fwd.sv
// Five-stage IF/ID/EX/MEM/WB integer pipeline with internal decode, register file,
// EX-stage operand forwarding, load-use interlock and EX-resolved branch/jump flush.
module pipe_datapath_fwd #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 12,
  parameter int unsigned DADDR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [DATA_W-1:0]  result_w,
  output logic               reg_write_w,
  output logic [3:0]         dest_w
);

  localparam int unsigned INST_W = 16;
  localparam int unsigned RIDX_W = 4;
  localparam int unsigned REG_N  = 16;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } if_id_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] rd_val;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_we;
    logic              is_load;
    logic [RIDX_W-1:0] dest;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic [RIDX_W-1:0] dest;
    logic [DATA_W-1:0] result;
  } mem_wb_t;

  // Decode helpers shared by the hazard unit and EX control.
  function automatic logic writes_reg(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW};
  endfunction

  function automatic logic uses_rs1(input logic [3:0] op);
    return op inside {[OP_ADD:OP_BEQ]};
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return op inside {[OP_ADD:OP_OR]};
  endfunction

  function automatic logic uses_rd(input logic [3:0] op);
    return op inside {OP_SW, OP_BEQ};
  endfunction

  // MEM result beats WB result beats the value read in ID.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [RIDX_W-1:0] src,
    input logic [DATA_W-1:0] id_val,
    input logic              mem_ok,
    input logic [RIDX_W-1:0] mem_dest,
    input logic [DATA_W-1:0] mem_val,
    input logic              wb_ok,
    input logic [RIDX_W-1:0] wb_dest,
    input logic [DATA_W-1:0] wb_val
  );
    if (mem_ok && (mem_dest == src)) return mem_val;
    if (wb_ok && (wb_dest == src))   return wb_val;
    return id_val;
  endfunction

  logic [PC_W-1:0]   pc;
  if_id_t            if_id;
  id_ex_t            id_ex;
  ex_mem_t           ex_mem;
  mem_wb_t           mem_wb;
  logic [DATA_W-1:0] rf [REG_N];

  // ID stage
  logic [3:0]        id_op;
  logic [RIDX_W-1:0] id_rd;
  logic [RIDX_W-1:0] id_rs1;
  logic [RIDX_W-1:0] id_rs2;
  logic              wb_we;
  logic [DATA_W-1:0] id_rs1_val;
  logic [DATA_W-1:0] id_rs2_val;
  logic [DATA_W-1:0] id_rd_val;
  logic              load_use;
  id_ex_t            id_ex_d;

  // EX stage
  logic [3:0]        ex_op;
  logic [RIDX_W-1:0] ex_rd;
  logic [RIDX_W-1:0] ex_rs1;
  logic [RIDX_W-1:0] ex_rs2;
  logic              mem_fwd_ok;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_d;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_alu;
  logic              taken;
  logic [PC_W-1:0]   target;
  ex_mem_t           ex_mem_d;

  // MEM stage
  mem_wb_t           mem_wb_d;

  assign id_op  = if_id.inst[15:12];
  assign id_rd  = if_id.inst[11:8];
  assign id_rs1 = if_id.inst[7:4];
  assign id_rs2 = if_id.inst[3:0];

  assign ex_op  = id_ex.inst[15:12];
  assign ex_rd  = id_ex.inst[11:8];
  assign ex_rs1 = id_ex.inst[7:4];
  assign ex_rs2 = id_ex.inst[3:0];

  assign wb_we      = mem_wb.reg_write && (mem_wb.dest != '0);
  assign mem_fwd_ok = ex_mem.reg_write && !ex_mem.is_load && (ex_mem.dest != '0);

  // Register read with same-cycle WB bypass; R0 is never written so reads 0.
  always_comb begin
    id_rs1_val = rf[id_rs1];
    id_rs2_val = rf[id_rs2];
    id_rd_val  = rf[id_rd];
    if (wb_we && (mem_wb.dest == id_rs1)) id_rs1_val = mem_wb.result;
    if (wb_we && (mem_wb.dest == id_rs2)) id_rs2_val = mem_wb.result;
    if (wb_we && (mem_wb.dest == id_rd))  id_rd_val  = mem_wb.result;
  end

  always_comb begin
    load_use = (ex_op == OP_LW) && (ex_rd != '0) &&
               ((uses_rs1(id_op) && (id_rs1 == ex_rd)) ||
                (uses_rs2(id_op) && (id_rs2 == ex_rd)) ||
                (uses_rd(id_op)  && (id_rd  == ex_rd)));
  end

  always_comb begin
    id_ex_d.inst    = if_id.inst;
    id_ex_d.pc      = if_id.pc;
    id_ex_d.rs1_val = id_rs1_val;
    id_ex_d.rs2_val = id_rs2_val;
    id_ex_d.rd_val  = id_rd_val;
  end

  // EX: operand forwarding, ALU, branch resolution.
  always_comb begin
    ex_a   = fwd(ex_rs1, id_ex.rs1_val, mem_fwd_ok, ex_mem.dest, ex_mem.alu,
                 wb_we, mem_wb.dest, mem_wb.result);
    ex_b   = fwd(ex_rs2, id_ex.rs2_val, mem_fwd_ok, ex_mem.dest, ex_mem.alu,
                 wb_we, mem_wb.dest, mem_wb.result);
    ex_d   = fwd(ex_rd, id_ex.rd_val, mem_fwd_ok, ex_mem.dest, ex_mem.alu,
                 wb_we, mem_wb.dest, mem_wb.result);
    ex_imm = {{(DATA_W-4){ex_rs2[3]}}, ex_rs2};
    ex_alu = '0;
    case (ex_op)
      OP_ADD:                ex_alu = ex_a + ex_b;
      OP_SUB:                ex_alu = ex_a - ex_b;
      OP_AND:                ex_alu = ex_a & ex_b;
      OP_OR:                 ex_alu = ex_a | ex_b;
      OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + ex_imm;
      default:               ex_alu = '0;
    endcase
    taken  = (ex_op == OP_JMP) || ((ex_op == OP_BEQ) && (ex_d == ex_a));
    target = id_ex.pc + PC_W'(1) +
             ((ex_op == OP_JMP) ? PC_W'($signed(id_ex.inst[11:0]))
                                : PC_W'($signed(ex_rs2)));
  end

  always_comb begin
    ex_mem_d.reg_write = writes_reg(ex_op);
    ex_mem_d.mem_we    = (ex_op == OP_SW);
    ex_mem_d.is_load   = (ex_op == OP_LW);
    ex_mem_d.dest      = ex_rd;
    ex_mem_d.alu       = ex_alu;
    ex_mem_d.sdata     = ex_d;
  end

  // MEM: load data is captured at the end of the MEM cycle.
  always_comb begin
    mem_wb_d.reg_write = ex_mem.reg_write;
    mem_wb_d.dest      = ex_mem.dest;
    mem_wb_d.result    = ex_mem.is_load ? dmem_rdata : ex_mem.alu;
  end

  // PC and pipeline registers: freeze, then flush, then load-use stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (enable) begin
      ex_mem <= ex_mem_d;
      mem_wb <= mem_wb_d;
      if (taken) begin
        pc    <= target;
        if_id <= '0;
        id_ex <= '0;
      end else if (load_use) begin
        id_ex <= '0;
      end else begin
        pc         <= pc + PC_W'(1);
        if_id.inst <= imem_rdata;
        if_id.pc   <= pc;
        id_ex      <= id_ex_d;
      end
    end
  end

  // Register file, written in WB; writes to R0 are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else if (enable && wb_we) begin
      rf[mem_wb.dest] <= mem_wb.result;
    end
  end

  assign imem_addr   = pc;
  assign dmem_addr   = DADDR_W'(ex_mem.alu);
  assign dmem_wdata  = ex_mem.sdata;
  assign dmem_we     = ex_mem.mem_we & enable;
  assign result_w    = mem_wb.result;
  assign reg_write_w = mem_wb.reg_write;
  assign dest_w      = mem_wb.dest;

endmodule
